// File: rtl/imu_burst_reader_if.sv
// Byte-level SPI master handshake between the IMU burst sequencer and the SPI shifter.
// The sequencer side is the master modport; the SPI byte engine is the slave modport.
interface imu_burst_reader_if;
    logic       spi_start;
    logic [7:0] spi_tx_data;
    logic       spi_cs_hold;
    logic       spi_busy;
    logic       spi_done;
    logic [7:0] spi_rx_data;

    modport master (
        output spi_start, spi_tx_data, spi_cs_hold,
        input  spi_busy, spi_done, spi_rx_data
    );

    modport slave (
        input  spi_start, spi_tx_data, spi_cs_hold,
        output spi_busy, spi_done, spi_rx_data
    );
endinterface

// File: rtl/imu_burst_reader.sv
// Periodic IMU burst reader: reads N_BYTES registers over SPI with SS held and
// publishes accel/temp/gyro as one atomic big-endian sample.
module imu_burst_reader #(
    parameter int         SAMPLE_PERIOD = 1000,
    parameter logic [7:0] START_REG     = 8'h3B,
    parameter int         N_BYTES       = 14,
    parameter int         TIMEOUT       = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    imu_burst_reader_if.master  spi,
    output logic signed [15:0]  accel_x,
    output logic signed [15:0]  accel_y,
    output logic signed [15:0]  accel_z,
    output logic signed [15:0]  temp,
    output logic signed [15:0]  gyro_x,
    output logic signed [15:0]  gyro_y,
    output logic signed [15:0]  gyro_z,
    output logic                sample_valid,
    output logic                overrun,
    output logic                timeout_err
);

    localparam int MAX_BYTES = 14;
    localparam int TMR_W     = $clog2(SAMPLE_PERIOD);
    localparam int WT_W      = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CMD, W_CMD, DAT, W_DAT, FIN} state_t;

    state_t           state, state_nxt;
    logic [TMR_W-1:0] tmr;
    logic             tick;
    logic [WT_W-1:0]  wt;
    logic             wt_expired;
    logic [3:0]       idx;
    logic [7:0]       shadow    [MAX_BYTES];
    logic [7:0]       bytes_nxt [MAX_BYTES];
    logic             capture;
    logic             last;
    logic             abort;

    assign tick       = enable && (tmr == TMR_W'(SAMPLE_PERIOD - 1));
    assign wt_expired = (wt == WT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || !enable || tick) begin
            tmr <= '0;
        end else begin
            tmr <= tmr + TMR_W'(1);
        end
    end

    always_comb begin
        state_nxt       = state;
        spi.spi_start   = 1'b0;
        spi.spi_tx_data = 8'h00;
        capture         = 1'b0;
        last            = 1'b0;
        abort           = 1'b0;
        case (state)
            IDLE: begin
                if (tick) state_nxt = CMD;
            end
            CMD: begin
                if (!spi.spi_busy) begin
                    spi.spi_start   = 1'b1;
                    spi.spi_tx_data = START_REG | 8'h80;
                    state_nxt       = W_CMD;
                end
            end
            W_CMD: begin
                if (spi.spi_done) begin
                    state_nxt = DAT;
                end else if (wt_expired) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DAT: begin
                if (!spi.spi_busy) begin
                    spi.spi_start = 1'b1;
                    state_nxt     = W_DAT;
                end
            end
            W_DAT: begin
                if (spi.spi_done) begin
                    capture = 1'b1;
                    if (idx == 4'(N_BYTES - 1)) begin
                        last      = 1'b1;
                        state_nxt = FIN;
                    end else begin
                        state_nxt = DAT;
                    end
                end else if (wt_expired) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shadow view including the byte arriving this cycle, so the final byte
    // lands in the published sample on the same edge as the FIN transition.
    always_comb begin
        for (int i = 0; i < MAX_BYTES; i++) bytes_nxt[i] = shadow[i];
        if (capture) bytes_nxt[idx] = spi.spi_rx_data;
    end

    assign spi.spi_cs_hold = (state == CMD) || (state == W_CMD) ||
                             (state == DAT) || (state == W_DAT);
    assign sample_valid    = (state == FIN);
    assign overrun         = tick && (state != IDLE);
    assign timeout_err     = abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            wt      <= '0;
            idx     <= '0;
            accel_x <= '0;
            accel_y <= '0;
            accel_z <= '0;
            temp    <= '0;
            gyro_x  <= '0;
            gyro_y  <= '0;
            gyro_z  <= '0;
            for (int i = 0; i < MAX_BYTES; i++) shadow[i] <= '0;
        end else begin
            state <= state_nxt;
            if ((state == W_CMD || state == W_DAT) && !spi.spi_done && !wt_expired) begin
                wt <= wt + WT_W'(1);
            end else begin
                wt <= '0;
            end
            if (state == W_CMD && spi.spi_done) begin
                idx <= '0;
            end else if (capture) begin
                idx <= idx + 4'd1;
            end
            if (capture) begin
                for (int i = 0; i < MAX_BYTES; i++) shadow[i] <= bytes_nxt[i];
            end
            if (last) begin
                accel_x <= $signed({bytes_nxt[0],  bytes_nxt[1]});
                accel_y <= $signed({bytes_nxt[2],  bytes_nxt[3]});
                accel_z <= $signed({bytes_nxt[4],  bytes_nxt[5]});
                temp    <= $signed({bytes_nxt[6],  bytes_nxt[7]});
                gyro_x  <= $signed({bytes_nxt[8],  bytes_nxt[9]});
                gyro_y  <= $signed({bytes_nxt[10], bytes_nxt[11]});
                gyro_z  <= $signed({bytes_nxt[12], bytes_nxt[13]});
            end
        end
    end

endmodule

// File: tb/tb_imu_burst_reader.sv
// Bench for imu_burst_reader: SPI slave model, transaction-level reference model
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_imu_burst_reader;

    localparam int P  = 100;
    localparam int N  = 14;
    localparam int TO = 300;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic signed [15:0] accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z;
    logic sample_valid, overrun, timeout_err;

    imu_burst_reader_if bus();

    imu_burst_reader #(
        .SAMPLE_PERIOD(P), .START_REG(8'h3B), .N_BYTES(N), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .spi(bus),
        .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z), .temp(temp),
        .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
        .sample_valid(sample_valid), .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: burst progress as byte counts, not controller states
    int         m_tmr = 0, m_sent = 0, m_got = 0, m_wt = 0;
    bit         m_active = 0, m_fin = 0;
    int         m_word [7];
    logic [7:0] m_bytes [N];

    // observation counters
    int ncyc = 0, last_done_cyc = 0, sv_gap = 0, to_gap = 0;
    int n_starts = 0, n_sv = 0, n_to = 0, n_ovr = 0;
    int start_cyc = -1;
    logic [7:0] start_tx = 8'h00;
    logic [7:0] tx_log [$];

    // SPI slave model
    int s_handled = -1, s_xfer = 0, s_extra = 0, s_extra_max = 0;
    int s_lat = 2, s_bnum = 0, stall_after = -1, dmode = 0;
    bit s_stalled = 0, stray_en = 0;
    logic [7:0] s_rx = 8'h00;

    int k0, s0, o0, n, zeros;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] data_byte(input int b);
        case (dmode)
            1:       data_byte = (b == 1) ? 8'hFF : (b == 2) ? 8'h38 : 8'(b);
            2:       data_byte = 8'($urandom);
            default: data_byte = 8'(b);
        endcase
    endfunction

    task automatic compare_and_advance();
        bit tick, sending, waiting, exp_start, expired;
        ncyc++;
        tick      = enable && (m_tmr == P - 1);
        sending   = m_active && (m_sent == m_got);
        waiting   = m_active && (m_sent == m_got + 1);
        exp_start = sending && !bus.spi_busy;
        expired   = waiting && !bus.spi_done && (m_wt == TO - 1);

        chk("spi_start", int'(bus.spi_start), int'(exp_start));
        if (bus.spi_start && exp_start)
            chk("spi_tx_data", int'(bus.spi_tx_data), (m_sent == 0) ? 'hBB : 0);
        chk("spi_cs_hold", int'(bus.spi_cs_hold), int'(m_active));
        chk("sample_valid", int'(sample_valid), int'(m_fin));
        chk("overrun", int'(overrun), int'(tick && (m_active || m_fin)));
        chk("timeout_err", int'(timeout_err), int'(expired));
        chk("accel_x", int'(accel_x), m_word[0]);
        chk("accel_y", int'(accel_y), m_word[1]);
        chk("accel_z", int'(accel_z), m_word[2]);
        chk("temp",    int'(temp),    m_word[3]);
        chk("gyro_x",  int'(gyro_x),  m_word[4]);
        chk("gyro_y",  int'(gyro_y),  m_word[5]);
        chk("gyro_z",  int'(gyro_z),  m_word[6]);

        if (bus.spi_start) begin
            start_cyc = ncyc;
            start_tx  = bus.spi_tx_data;
            n_starts++;
            tx_log.push_back(bus.spi_tx_data);
        end
        if (bus.spi_done) last_done_cyc = ncyc;
        if (sample_valid) begin n_sv++; sv_gap = ncyc - last_done_cyc; end
        if (timeout_err)  begin n_to++; to_gap = ncyc - last_done_cyc; end
        if (overrun) n_ovr++;

        if (rst) begin
            m_tmr = 0; m_active = 0; m_fin = 0; m_sent = 0; m_got = 0; m_wt = 0;
            for (int i = 0; i < 7; i++) m_word[i] = 0;
            for (int i = 0; i < N; i++) m_bytes[i] = 8'h00;
        end else begin
            m_tmr = enable ? (tick ? 0 : m_tmr + 1) : 0;
            if (m_fin) begin
                m_fin = 0;
            end else if (!m_active) begin
                if (tick) begin m_active = 1; m_sent = 0; m_got = 0; m_wt = 0; end
            end else if (sending) begin
                m_wt = 0;
                if (!bus.spi_busy) m_sent++;
            end else if (bus.spi_done) begin
                if (m_got > 0) m_bytes[m_got-1] = bus.spi_rx_data;
                m_got++;
                m_wt = 0;
                if (m_got == N + 1) begin
                    m_active = 0;
                    m_fin    = 1;
                    for (int k = 0; k < 7; k++)
                        m_word[k] = (2*k + 1 < N) ? int'($signed({m_bytes[2*k], m_bytes[2*k+1]})) : 0;
                end
            end else if (expired) begin
                m_active = 0;
            end else begin
                m_wt++;
            end
        end
    endtask

    task automatic slave_drive();
        bus.spi_done = 1'b0;
        if (s_xfer > 0) begin
            s_xfer--;
            if (s_xfer == 0) begin
                if (s_stalled) begin
                    bus.spi_busy = 1'b0;
                end else begin
                    bus.spi_done    = 1'b1;
                    bus.spi_rx_data = s_rx;
                    s_extra = (s_extra_max > 0) ? $urandom_range(0, s_extra_max) : 0;
                    bus.spi_busy = (s_extra > 0);
                end
            end
        end else if (s_extra > 0) begin
            s_extra--;
            if (s_extra == 0) bus.spi_busy = 1'b0;
        end
        if (start_cyc != s_handled) begin
            s_handled = start_cyc;
            if (start_tx == 8'hBB) begin
                s_bnum = 0;
                s_rx   = 8'($urandom);
            end else begin
                s_bnum++;
                s_rx = data_byte(s_bnum);
            end
            s_stalled    = (stall_after >= 0) && (s_bnum > stall_after);
            bus.spi_busy = 1'b1;
            s_xfer       = s_lat;
        end else if (stray_en && !bus.spi_busy && !bus.spi_done && s_xfer == 0 &&
                     $urandom_range(0, 15) == 0) begin
            bus.spi_done    = 1'b1;
            bus.spi_rx_data = 8'($urandom);
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare_and_advance();
        @(posedge clk);
        #1;
        slave_drive();
    endtask

    task automatic wait_sv(input string nm, input int budget);
        int k, c;
        k = n_sv; c = 0;
        while (n_sv == k && c < budget) begin step(); c++; end
        chk(nm, int'(n_sv != k), 1);
    endtask

    task automatic wait_to(input string nm, input int budget);
        int k, c;
        k = n_to; c = 0;
        while (n_to == k && c < budget) begin step(); c++; end
        chk(nm, int'(n_to != k), 1);
    endtask

    task automatic wait_byte(input string nm, input int b, input int budget);
        int c;
        c = 0;
        while (!(s_bnum == b && s_xfer > 0) && c < budget) begin step(); c++; end
        chk(nm, int'(s_bnum == b && s_xfer > 0), 1);
    endtask

    initial begin
        for (int i = 0; i < 7; i++) m_word[i] = 0;
        for (int i = 0; i < N; i++) m_bytes[i] = 8'h00;
        rst = 1'b1; enable = 1'b0;
        bus.spi_busy = 1'b0; bus.spi_done = 1'b0; bus.spi_rx_data = 8'h00;
        @(posedge clk); #1;
        repeat (3) step();
        chk("reset_accel_x", int'(accel_x), 0);
        chk("reset_gyro_z", int'(gyro_z), 0);
        chk("reset_cs_hold", int'(bus.spi_cs_hold), 0);
        rst = 1'b0; enable = 1'b1;

        // incrementing bytes 01..0E
        dmode = 0; s_lat = 2;
        tx_log.delete();
        wait_sv("t1_sample_seen", 400);
        chk("t1_accel_x", int'(accel_x), 'h0102);
        chk("t1_gyro_z", int'(gyro_z), 'h0D0E);
        chk("t1_temp", int'(temp), 'h0708);
        chk("t1_one_sample", n_sv, 1);
        chk("t1_tx_count", tx_log.size(), 15);
        chk("t1_tx_cmd", int'(tx_log[0]), 'hBB);
        zeros = 0;
        for (int i = 1; i < tx_log.size(); i++) if (tx_log[i] == 8'h00) zeros++;
        chk("t1_tx_zero_bytes", zeros, 14);

        // negative accel_x, latency of sample_valid
        dmode = 1;
        wait_sv("t2_sample_seen", 400);
        chk("t2_accel_x", int'(accel_x), -200);
        chk("t2_accel_y", int'(accel_y), 'h0304);
        chk("t2_sv_latency", sv_gap, 1);

        // slave slower than the sample period
        dmode = 0; s_lat = 130;
        s0 = n_starts; o0 = n_ovr;
        wait_sv("t3_sample_seen", 4000);
        chk("t3_starts_one_burst", n_starts - s0, 15);
        chk("t3_overrun_seen", int'(n_ovr > o0), 1);
        chk("t3_accel_x", int'(accel_x), 'h0102);

        // slave stops after byte 5
        s_lat = 2; stall_after = 5;
        wait_to("t4_timeout_seen", 800);
        chk("t4_timeout_latency", to_gap, TO + 1);
        chk("t4_accel_x_kept", int'(accel_x), 'h0102);
        chk("t4_gyro_z_kept", int'(gyro_z), 'h0D0E);
        chk("t4_cs_hold_dropped", int'(bus.spi_cs_hold), 0);
        stall_after = -1;
        s0 = n_starts;
        wait_sv("t4_clean_burst", 400);
        chk("t4_clean_starts", n_starts - s0, 15);
        chk("t4_clean_gyro_z", int'(gyro_z), 'h0D0E);

        // reset during byte 7
        wait_byte("t5_reach_byte7", 7, 400);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_cs_hold_zero", int'(bus.spi_cs_hold), 0);
        chk("t5_accel_x_zero", int'(accel_x), 0);
        chk("t5_gyro_z_zero", int'(gyro_z), 0);
        k0 = n_starts; n = 0;
        while (n_starts == k0 && n < 300) begin step(); n++; end
        chk("t5_first_start_cycle", n, P + 1);

        // enable dropped mid-burst
        wait_byte("t6_reach_byte3", 3, 400);
        enable = 1'b0;
        wait_sv("t6_burst_completes", 400);
        s0 = n_starts;
        repeat (3 * P) step();
        chk("t6_no_new_start", n_starts - s0, 0);
        enable = 1'b1;

        // randomized traffic
        dmode = 2; stray_en = 1; s_extra_max = 2;
        for (int i = 0; i < 8000; i++) begin
            s_lat = $urandom_range(1, 5);
            if (enable && $urandom_range(0, 399) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 49) == 0) enable = 1'b1;
            rst = ($urandom_range(0, 1999) == 0);
            step();
        end
        rst = 1'b0;
        repeat (5) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
